// File: rtl/simplez_ctrl_if.sv
// Memory handshake bundle between the Simplez control unit and memory.
//   mem_req  : access request, held until mem_ack is sampled high
//   mem_we   : write qualifier, valid while mem_req=1
//   addr_sel : address source, 0 = PC, 1 = RI[8:0]
//   mem_ack  : memory completes the current access
interface simplez_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/simplez_ctrl.sv
// Simplez instruction sequencer: fetch/decode/execute FSM over the 8 opcodes,
// one-hot datapath strobes, memory handshake with bus timeout, HALT/fault stop.
// Ports:
//   clk, rstn          clock (rising), async active-low reset
//   run                1 = execute, 0 = park at the next FETCH boundary
//   opcode, zero       RI[11:9] and ACC==0 flag from the datapath
//   bus (master)       mem_req / mem_we / addr_sel / mem_ack
//   pc_clr/inc/load    PC strobes
//   ri_load            RI <= memory read data
//   acc_load, alu_add  ACC <= ALU result (alu_add: ACC + mem, else mem)
//   acc_clr, acc_dec   ACC <= 0 / ACC - 1
//   stop, fault        halted (HALT or bus fault) / bus timeout, sticky
//   icount             retired-instruction count
module simplez_ctrl #(
    parameter int TMO    = 255,
    parameter int TMO_W  = 8,
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic [2:0]        opcode,
    input  logic              zero,
    simplez_ctrl_if.master    bus,
    output logic              pc_clr,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              ri_load,
    output logic              acc_load,
    output logic              alu_add,
    output logic              acc_clr,
    output logic              acc_dec,
    output logic              stop,
    output logic              fault,
    output logic [ICNT_W-1:0] icount
);
    localparam logic [2:0] OP_ST  = 3'd0, OP_LD  = 3'd1, OP_ADD = 3'd2, OP_BR = 3'd3,
                           OP_BZ  = 3'd4, OP_CLR = 3'd5, OP_DEC = 3'd6;

    typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR, S_HALT} state_t;

    state_t              state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ICNT_W-1:0]   icnt_q, icnt_d;
    logic                fault_q, fault_d;
    logic                busy_q, busy_d;   // a fetch request is outstanding

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_INIT;
            tmo_q   <= '0;
            icnt_q  <= '0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            icnt_q  <= icnt_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmo_d        = '0;
        icnt_d       = icnt_q;
        fault_d      = fault_q;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        pc_clr       = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        ri_load      = 1'b0;
        acc_load     = 1'b0;
        alu_add      = 1'b0;
        acc_clr      = 1'b0;
        acc_dec      = 1'b0;

        unique case (state_q)
            // Gated by rstn so pc_clr stays low while reset is held.
            S_INIT: begin
                pc_clr  = rstn;
                state_d = S_FETCH;
            end
            // Once a fetch is issued it is held to completion even if run drops.
            S_FETCH: begin
                if (run || busy_q) begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        ri_load = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                icnt_d  = icnt_q + 1'b1;
                unique case (opcode)
                    OP_ST:         begin state_d = S_MEM_WR; icnt_d = icnt_q; end
                    OP_LD, OP_ADD: begin state_d = S_MEM_RD; icnt_d = icnt_q; end
                    OP_BR:         pc_load = 1'b1;
                    OP_BZ:         pc_load = zero;
                    OP_CLR:        acc_clr = 1'b1;
                    OP_DEC:        acc_dec = 1'b1;
                    default:       begin state_d = S_HALT;   icnt_d = icnt_q; end
                endcase
            end
            S_MEM_RD: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                alu_add      = (opcode == OP_ADD);
                if (bus.mem_ack) begin
                    acc_load = 1'b1;
                    icnt_d   = icnt_q + 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEM_WR: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.addr_sel = 1'b1;
                if (bus.mem_ack) begin
                    icnt_d  = icnt_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase

        // Timeout counter only advances on unacknowledged request cycles;
        // the TMO-th such cycle faults instead of counting further.
        busy_d = bus.mem_req && !bus.mem_ack;
        if (busy_d) begin
            if (tmo_q == TMO_W'(TMO - 1)) begin
                fault_d = 1'b1;
                state_d = S_HALT;
                busy_d  = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign stop   = (state_q == S_HALT);
    assign fault  = fault_q;
    assign icount = icnt_q;
endmodule
